// File: rtl/logic_gate_pkg.sv
// Shared types and helpers for the reprogrammable truth-table gate.
package logic_gate_pkg;
  localparam int MAX_N_IN  = 6;
  localparam int MAX_N_OUT = 8;

  typedef enum logic [1:0] {UNCFG, LOAD, READY} lg_state_e;

  function automatic int tbits(input int n_in, input int n_out);
    return n_out * (1 << n_in);
  endfunction
endpackage

// File: rtl/logic_gate_lut_if.sv
// Config/evaluation bus of logic_gate_lut; master drives stimulus, slave is the block.
interface logic_gate_lut_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1
);
  logic             i_CFG_START;
  logic             i_CFG_VALID;
  logic             i_CFG_BIT;
  logic             o_CFG_DONE;
  logic             o_READY;
  logic             i_VALID;
  logic [N_IN-1:0]  i_IN;
  logic             o_VALID;
  logic [N_OUT-1:0] o_Y;

  modport master (
    output i_CFG_START, i_CFG_VALID, i_CFG_BIT, i_VALID, i_IN,
    input  o_CFG_DONE, o_READY, o_VALID, o_Y
  );
  modport slave (
    input  i_CFG_START, i_CFG_VALID, i_CFG_BIT, i_VALID, i_IN,
    output o_CFG_DONE, o_READY, o_VALID, o_Y
  );
endinterface

// File: rtl/logic_gate_cfg_loader.sv
// Serial truth-table loader: MSB-first shift-in, bit counter and UNCFG/LOAD/READY FSM.
module logic_gate_cfg_loader
  import logic_gate_pkg::*;
#(
  parameter int TBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  output logic             cfg_done,
  output logic             ready,
  output logic [TBITS-1:0] tbl
);
  localparam int CW = $clog2(TBITS + 1);

  lg_state_e        state, state_n;
  logic [CW-1:0]    cnt, cnt_n, idx;
  logic [TBITS-1:0] tbl_n;
  logic             done_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tbl_n   = tbl;
    done_n  = 1'b0;
    idx     = cnt;
    case (state)
      UNCFG: if (cfg_start) begin state_n = LOAD; cnt_n = '0; end
      LOAD: begin
        // a restart with a simultaneous bit makes that bit number 0
        idx   = cfg_start ? '0 : cnt;
        cnt_n = idx;
        if (cfg_valid) begin
          tbl_n = {tbl[TBITS-2:0], cfg_bit};
          if (idx == CW'(TBITS - 1)) begin
            cnt_n   = '0;
            state_n = READY;
            done_n  = 1'b1;
          end else begin
            cnt_n = idx + CW'(1);
          end
        end
      end
      READY: if (cfg_start) begin state_n = LOAD; cnt_n = '0; end
      default: state_n = UNCFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= UNCFG;
      cnt      <= '0;
      tbl      <= '0;
      cfg_done <= 1'b0;
      ready    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tbl      <= tbl_n;
      cfg_done <= done_n;
      ready    <= (state_n == READY);
    end
  end
endmodule

// File: rtl/logic_gate_lut.sv
// N_OUT run-time loadable Boolean functions of one N_IN-bit vector, LATENCY-cycle registered output.
module logic_gate_lut
  import logic_gate_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 1,
  parameter int LATENCY = 1
) (
  input logic              i_CLK,
  input logic              i_RST_N,
  logic_gate_lut_if.slave  bus
);
  localparam int TSZ   = 1 << N_IN;
  localparam int TBITS = tbits(N_IN, N_OUT);

  logic [TBITS-1:0] tbl;
  logic             ready;

  logic_gate_cfg_loader #(.TBITS(TBITS)) u_cfg (
    .clk      (i_CLK),
    .rst_n    (i_RST_N),
    .cfg_start(bus.i_CFG_START),
    .cfg_valid(bus.i_CFG_VALID),
    .cfg_bit  (bus.i_CFG_BIT),
    .cfg_done (bus.o_CFG_DONE),
    .ready    (ready),
    .tbl      (tbl)
  );
  assign bus.o_READY = ready;

  logic [N_OUT-1:0] res;
  for (genvar c = 0; c < N_OUT; c++) begin : g_fn
    logic [TSZ-1:0] fn;
    assign fn     = tbl[c*TSZ +: TSZ];
    assign res[c] = fn[bus.i_IN];
  end

  // a reload request in READY discards everything in flight, including this cycle's sample
  logic flush, s0_vld;
  assign flush  = ready & bus.i_CFG_START;
  assign s0_vld = ready & bus.i_VALID & ~bus.i_CFG_START;

  logic [LATENCY:1]            vld_pipe;
  logic [LATENCY:1][N_OUT-1:0] y_pipe;
  logic [LATENCY:0]            vld_chain;
  logic [LATENCY:0][N_OUT-1:0] y_chain;
  assign vld_chain = {vld_pipe, s0_vld};
  assign y_chain   = {y_pipe, res};

  // data stages only advance with a live valid, so o_Y holds between results
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      vld_pipe <= '0;
      y_pipe   <= '0;
    end else begin
      for (int k = 1; k <= LATENCY; k++) begin
        vld_pipe[k] <= vld_chain[k-1] & ~flush;
        if (vld_chain[k-1] & ~flush) y_pipe[k] <= y_chain[k-1];
      end
    end
  end

  assign bus.o_VALID = vld_pipe[LATENCY];
  assign bus.o_Y     = y_pipe[LATENCY];
endmodule

// File: tb/tb_logic_gate_lut.sv
// Directed bench for logic_gate_lut: default instance plus an N_OUT=2/LATENCY=2 instance.
module tb_logic_gate_lut;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [2] = '{1'b0, 1'b0};
  logic       cfg_start [2] = '{1'b0, 1'b0};
  logic       cfg_valid [2] = '{1'b0, 1'b0};
  logic       cfg_bit   [2] = '{1'b0, 1'b0};
  logic       vin       [2] = '{1'b0, 1'b0};
  logic [3:0] din       [2] = '{4'h0, 4'h0};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int NO = gi + 1;
    localparam int LT = gi + 1;
    localparam int TB = NO * 16;

    logic_gate_lut_if #(.N_IN(4), .N_OUT(NO)) bus ();
    assign bus.i_CFG_START = cfg_start[gi];
    assign bus.i_CFG_VALID = cfg_valid[gi];
    assign bus.i_CFG_BIT   = cfg_bit[gi];
    assign bus.i_VALID     = vin[gi];
    assign bus.i_IN        = din[gi];

    logic_gate_lut #(.N_IN(4), .N_OUT(NO), .LATENCY(LT)) dut (
      .i_CLK  (clk),
      .i_RST_N(rst_n[gi]),
      .bus    (bus)
    );

    // Model: table as a plain bit vector, results queued with their due cycle.
    logic [TB-1:0] m_tbl = '0;
    bit            m_load = 1'b0, m_ready = 1'b0, was_load;
    int            m_n = 0, cyc = 0;
    int            due_q [$];
    logic [NO-1:0] y_q   [$];
    bit            exp_v = 1'b0, exp_done = 1'b0;
    logic [NO-1:0] exp_y = '0;

    function automatic logic [NO-1:0] fn_eval(input logic [TB-1:0] t, input logic [3:0] x);
      logic [NO-1:0] r;
      logic [TB-1:0] s;
      for (int c = 0; c < NO; c++) begin
        s    = t >> (c * 16 + int'(x));
        r[c] = s[0];
      end
      return r;
    endfunction

    always @(posedge clk or negedge rst_n[gi]) begin
      if (!rst_n[gi]) begin
        m_tbl = '0; m_load = 1'b0; m_ready = 1'b0; m_n = 0;
        due_q.delete(); y_q.delete();
        exp_v = 1'b0; exp_done = 1'b0; exp_y = '0;
      end else begin
        cyc++;
        exp_done = 1'b0;
        if (m_ready && vin[gi] && !cfg_start[gi]) begin
          due_q.push_back(cyc + LT - 1);
          y_q.push_back(fn_eval(m_tbl, din[gi]));
        end
        was_load = m_load;
        if (cfg_start[gi]) begin
          if (m_ready) begin due_q.delete(); y_q.delete(); end
          m_ready = 1'b0; m_load = 1'b1; m_n = 0;
        end
        if (was_load && cfg_valid[gi]) begin
          m_tbl = {m_tbl[TB-2:0], cfg_bit[gi]};
          m_n++;
          if (m_n == TB) begin
            m_load = 1'b0; m_ready = 1'b1; m_n = 0; exp_done = 1'b1;
          end
        end
        exp_v = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          exp_v = 1'b1;
          exp_y = y_q[0];
          void'(due_q.pop_front());
          void'(y_q.pop_front());
        end
      end
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d.o_READY", gi),    bus.o_READY,    m_ready);
      chk($sformatf("g%0d.o_CFG_DONE", gi), bus.o_CFG_DONE, exp_done);
      chk($sformatf("g%0d.o_VALID", gi),    bus.o_VALID,    exp_v);
      chk($sformatf("g%0d.o_Y", gi),        bus.o_Y,        exp_y);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int n, input logic [31:0] v);
    cfg_start[k] = 1'b1;
    tick();
    cfg_start[k] = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      cfg_valid[k] = 1'b1;
      cfg_bit[k]   = v[i];
      tick();
    end
    cfg_valid[k] = 1'b0;
  endtask

  initial begin
    logic [15:0] or4;
    or4 = 16'hFFFE;
    repeat (3) tick();
    chk("reset_ready", g_inst[0].bus.o_READY, 0);
    chk("reset_y",     g_inst[0].bus.o_Y,     0);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // i_VALID while unconfigured yields nothing
    vin[0] = 1'b1; din[0] = 4'hF;
    repeat (3) tick();
    vin[0] = 1'b0;
    chk("uncfg_valid", g_inst[0].bus.o_VALID, 0);

    // AND4
    load(0, 16, 32'h8000);
    chk("and4_done",  g_inst[0].bus.o_CFG_DONE, 1);
    chk("and4_ready", g_inst[0].bus.o_READY,    1);
    vin[0] = 1'b1; din[0] = 4'hF;
    tick();
    chk("and4_done_once", g_inst[0].bus.o_CFG_DONE, 0);
    chk("and4_F_v", g_inst[0].bus.o_VALID, 1);
    chk("and4_F",   g_inst[0].bus.o_Y,     1);
    din[0] = 4'hE;
    tick();
    chk("and4_E_v", g_inst[0].bus.o_VALID, 1);
    chk("and4_E",   g_inst[0].bus.o_Y,     0);
    vin[0] = 1'b0;
    tick();
    chk("and4_idle_v", g_inst[0].bus.o_VALID, 0);

    // config bits in READY are ignored; table unchanged
    cfg_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin cfg_bit[0] = i[0]; tick(); end
    cfg_valid[0] = 1'b0;
    vin[0] = 1'b1; din[0] = 4'hF;
    tick();
    chk("ign_F", g_inst[0].bus.o_Y, 1);
    din[0] = 4'hE;
    tick();
    chk("ign_E", g_inst[0].bus.o_Y, 0);
    vin[0] = 1'b0;

    // XOR4 sweep
    load(0, 16, 32'h6996);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] x;
      x = 4'(i);
      vin[0] = 1'b1; din[0] = x;
      tick();
      chk($sformatf("xor4_%0d", i), g_inst[0].bus.o_Y, ^x);
    end
    vin[0] = 1'b0;

    // restart mid-load, then OR4 with the first bit riding on the restart
    cfg_start[0] = 1'b1; tick(); cfg_start[0] = 1'b0;
    cfg_valid[0] = 1'b1;
    for (int i = 0; i < 7; i++) begin cfg_bit[0] = ~i[0]; tick(); end
    cfg_start[0] = 1'b1; cfg_bit[0] = or4[15];
    tick();
    cfg_start[0] = 1'b0;
    for (int i = 14; i >= 0; i--) begin cfg_bit[0] = or4[i]; tick(); end
    cfg_valid[0] = 1'b0;
    chk("or4_done", g_inst[0].bus.o_CFG_DONE, 1);
    vin[0] = 1'b1; din[0] = 4'h0;
    tick();
    chk("or4_0", g_inst[0].bus.o_Y, 0);
    din[0] = 4'h4;
    tick();
    chk("or4_4", g_inst[0].bus.o_Y, 1);

    // reload request while streaming flushes outputs
    din[0] = 4'h1; tick();
    cfg_start[0] = 1'b1; din[0] = 4'h2;
    tick();
    cfg_start[0] = 1'b0;
    chk("flush_v0", g_inst[0].bus.o_VALID, 0);
    chk("flush_hold", g_inst[0].bus.o_Y, 1);
    repeat (4) tick();
    vin[0] = 1'b0;
    cfg_valid[0] = 1'b1;
    repeat (5) tick();
    cfg_valid[0] = 1'b0;

    // async reset mid-load
    rst_n[0] = 1'b0;
    #1;
    chk("rst_ready", g_inst[0].bus.o_READY,    0);
    chk("rst_y",     g_inst[0].bus.o_Y,        0);
    chk("rst_done",  g_inst[0].bus.o_CFG_DONE, 0);
    tick(); tick();
    rst_n[0] = 1'b1;
    vin[0] = 1'b1; din[0] = 4'hF;
    repeat (3) tick();
    vin[0] = 1'b0;
    load(0, 16, 32'h8000);
    vin[0] = 1'b1; din[0] = 4'hF;
    tick();
    chk("reload_F", g_inst[0].bus.o_Y, 1);
    vin[0] = 1'b0;

    // N_OUT=2, LATENCY=2: f1=AND4, f0=OR4
    load(1, 32, 32'h8000_FFFE);
    vin[1] = 1'b1; din[1] = 4'h3;
    tick();
    chk("l2_first_v", g_inst[1].bus.o_VALID, 0);
    din[1] = 4'hF;
    tick();
    chk("l2_3_v", g_inst[1].bus.o_VALID, 1);
    chk("l2_3",   g_inst[1].bus.o_Y,     2'b01);
    din[1] = 4'h0;
    tick();
    chk("l2_F", g_inst[1].bus.o_Y, 2'b11);
    vin[1] = 1'b0;
    tick();
    chk("l2_0", g_inst[1].bus.o_Y, 2'b00);
    tick();
    chk("l2_idle_v", g_inst[1].bus.o_VALID, 0);

    // flush with two stages in flight
    vin[1] = 1'b1; din[1] = 4'hF;
    repeat (3) tick();
    cfg_start[1] = 1'b1;
    tick();
    cfg_start[1] = 1'b0;
    chk("l2_flush_v", g_inst[1].bus.o_VALID, 0);
    repeat (3) tick();
    vin[1] = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
